issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of queue slots (power of two, 4..32).
REQ-002 SHALL have parameter TAG_W, default `PROJ_LOG_PHYS (6), physical-register tag width.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  in  1  synchronous, active-low reset.
REQ-005 SHALL have port Entry_IN  in  `ISSUE_QUEUE_ENTRY_BITS (67)  renamed instruction, MSB first: ALU_Control[6], HasImm[1], Imm[32], SrcA[6], ReadyA[1], SrcB[6], ReadyB[1], Shamt[5], HasDest[1], Dest[6], MemWrite[1], MemRead[1].
REQ-006 SHALL have port Entry_valid_IN  in  1  insert request from rename.
REQ-007 SHALL have port Full_OUT  out  1  no free slot; drives rename's Issue_queue_full.
REQ-008 SHALL have port Count_OUT  out  $clog2(DEPTH)+1  occupied slots.
REQ-009 SHALL have port Wakeup_valid_IN  in  1  writeback broadcast valid.
REQ-010 SHALL have port Wakeup_tag_IN  in  TAG_W  physical register just written.
REQ-011 SHALL have port Issue_entry_OUT  out  67  selected entry, both ready bits set.
REQ-012 SHALL have port Issue_valid_OUT  out  1  Issue_entry_OUT holds a valid entry.
REQ-013 SHALL have port Exec_ready_IN  in  1  execute accepts Issue_entry_OUT this edge.
REQ-014 SHALL have port Flush_IN  in  1  discard all queued and output-held entries.

Function
REQ-015 Insert: on edge with Entry_valid_IN=1 and Full_OUT=0, SHALL write Entry_IN into a free slot as youngest; insert while Full_OUT=1 SHALL be dropped, state unchanged.
REQ-016 Full_OUT SHALL equal (Count_OUT==DEPTH), derived from registered state only; same-edge issue SHALL NOT unblock a same-edge insert.
REQ-017 Wakeup: with Wakeup_valid_IN=1 and Wakeup_tag_IN!=0, every stored entry whose SrcA/SrcB matches SHALL set ReadyA/ReadyB on that edge; the entry being inserted on that edge SHALL also be matched.
REQ-018 Wakeup tag 0 SHALL be ignored (phys 0 is permanently ready).
REQ-019 Eligible = stored, ReadyA=1, ReadyB=1; select SHALL pick the oldest eligible entry by strict insertion order.
REQ-020 Output register loads when (!Issue_valid_OUT || Exec_ready_IN): with selected entry (slot freed, Issue_valid_OUT=1) or Issue_valid_OUT=0 if none eligible.
REQ-021 Transfer to execute SHALL occur exactly on edges with Issue_valid_OUT=1 and Exec_ready_IN=1; output held stable otherwise.
REQ-022 Latency: entry inserted already ready at edge N SHALL reach Issue_valid_OUT=1 at edge N+1 if output register loadable and no older eligible entry.
REQ-023 Count_OUT SHALL update as +1 insert, -1 slot moved to output register, both same edge = unchanged.
REQ-024 Flush_IN=1 SHALL, on that edge, clear all slots, Issue_valid_OUT, Count_OUT; priority over insert, wakeup, issue.
REQ-025 Relative age of remaining entries SHALL be preserved across removals from any slot.

Reset
REQ-026 RESET=0 at edge SHALL clear all slot valids, Count_OUT=0, Issue_valid_OUT=0, Issue_entry_OUT=0; Full_OUT=0 follows; priority over Flush_IN and all inputs, including mid-operation.

Configuration
REQ-027 Macro ISSUE_QUEUE_BYPASS_EN defined: select SHALL treat an operand matching the current-cycle wakeup as ready, so the woken entry may load the output register on the wakeup edge (set both ready bits in loaded copy).
REQ-028 Macro undefined: eligibility SHALL use stored ready bits only; woken entry earliest loads output one edge after wakeup.

Verification
REQ-029 Reset, insert ready ALU entry (SrcA=SrcB=0, Dest=5) with Exec_ready_IN=1 -> Issue_valid_OUT=1 next edge, Count_OUT back to 0.
REQ-030 Insert A (SrcA=7 not ready) then B (ready); both queued -> B issues first, A waits; wakeup tag 7 -> A issues next (same edge with BYPASS_EN, one edge later without).
REQ-031 Fill 16 entries with Exec_ready_IN=0 -> Full_OUT=1, 17th insert dropped, Count_OUT=16; assert Exec_ready_IN one edge -> Count_OUT=15, Full_OUT=0.
REQ-032 Insert entry SrcB=9 on same edge as wakeup tag 9 -> entry stored with ReadyB=1, issues without further wakeup.
REQ-033 Queue holding 5 entries plus valid output, Flush_IN=1 with simultaneous insert -> Count_OUT=0, Issue_valid_OUT=0, inserted entry discarded.
REQ-034 RESET=0 asserted while Issue_valid_OUT=1 and Exec_ready_IN=0 -> next edge all outputs zero, no transfer counted.

Source files
------------

// File: rtl/issue_queue_if.sv
// Rename/writeback/execute-facing bundle of the issue queue; the queue takes the slave modport.
`ifndef PROJ_LOG_PHYS
`define PROJ_LOG_PHYS 6
`endif
`ifndef ISSUE_QUEUE_ENTRY_BITS
`define ISSUE_QUEUE_ENTRY_BITS 67
`endif

interface issue_queue_if #(
  parameter int DEPTH = 16,
  parameter int TAG_W = `PROJ_LOG_PHYS
);
  localparam int EW = `ISSUE_QUEUE_ENTRY_BITS;
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: insert happens on an edge with Entry_valid_IN=1 and Full_OUT=0 (no backpressure
  // wait, a refused insert is dropped); transfer to execute happens on an edge with
  // Issue_valid_OUT=1 and Exec_ready_IN=1, and the output holds stable until then.
  logic [EW-1:0]    Entry_IN;
  logic             Entry_valid_IN;
  logic             Full_OUT;
  logic [CW-1:0]    Count_OUT;
  logic             Wakeup_valid_IN;
  logic [TAG_W-1:0] Wakeup_tag_IN;
  logic [EW-1:0]    Issue_entry_OUT;
  logic             Issue_valid_OUT;
  logic             Exec_ready_IN;
  logic             Flush_IN;

  modport master (
    output Entry_IN, Entry_valid_IN, Wakeup_valid_IN, Wakeup_tag_IN, Exec_ready_IN, Flush_IN,
    input  Full_OUT, Count_OUT, Issue_entry_OUT, Issue_valid_OUT
  );

  modport slave (
    input  Entry_IN, Entry_valid_IN, Wakeup_valid_IN, Wakeup_tag_IN, Exec_ready_IN, Flush_IN,
    output Full_OUT, Count_OUT, Issue_entry_OUT, Issue_valid_OUT
  );
endinterface

// File: rtl/issue_queue.sv
// Age-ordered collapsing issue queue with tag wakeup and oldest-ready select.
// Optional ISSUE_QUEUE_BYPASS_EN lets a same-edge wakeup make an entry selectable.
`ifndef PROJ_LOG_PHYS
`define PROJ_LOG_PHYS 6
`endif
`ifndef ISSUE_QUEUE_ENTRY_BITS
`define ISSUE_QUEUE_ENTRY_BITS 67
`endif

module issue_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = `PROJ_LOG_PHYS
) (
  input logic         CLK,
  input logic         RESET,
  issue_queue_if.slave q
);
  localparam int EW = `ISSUE_QUEUE_ENTRY_BITS;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int SRCA_LO = 22;
  localparam int RDYA    = 21;
  localparam int SRCB_LO = 15;
  localparam int RDYB    = 14;

  // Slot 0 is always the oldest; slots at index >= count hold don't-care data.
  logic [EW-1:0] slots      [DEPTH];
  logic [EW-1:0] slots_nxt  [DEPTH];
  logic [EW-1:0] woken      [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] wpos;
  logic [DEPTH-1:0] elig;
  logic [IW-1:0] sel;
  logic          found;
  logic          full;
  logic          load;
  logic          do_issue;
  logic          do_insert;
  logic [EW-1:0] ins_woken;
  logic [EW-1:0] issue_sel;
  logic [EW-1:0] issue_entry;
  logic          issue_valid;

  function automatic logic [EW-1:0] wake(input logic [EW-1:0] e, input logic v,
                                         input logic [TAG_W-1:0] t);
    logic [EW-1:0] r;
    r = e;
    if (v && (t != '0)) begin
      if (TAG_W'(e[SRCA_LO +: 6]) == t) r[RDYA] = 1'b1;
      if (TAG_W'(e[SRCB_LO +: 6]) == t) r[RDYB] = 1'b1;
    end
    return r;
  endfunction

  assign full = (count == CW'(DEPTH));

  always_comb begin
    found     = 1'b0;
    sel       = '0;
    elig      = '0;
    load      = !issue_valid || q.Exec_ready_IN;
    do_insert = q.Entry_valid_IN && !full;
    ins_woken = wake(q.Entry_IN, q.Wakeup_valid_IN, q.Wakeup_tag_IN);
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = wake(slots[i], q.Wakeup_valid_IN, q.Wakeup_tag_IN);
`ifdef ISSUE_QUEUE_BYPASS_EN
      elig[i] = (CW'(i) < count) && woken[i][RDYA] && woken[i][RDYB];
`else
      elig[i] = (CW'(i) < count) && slots[i][RDYA] && slots[i][RDYB];
`endif
    end
    // Descending scan so the lowest (oldest) eligible index wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
    do_issue  = load && found;
    issue_sel = woken[sel];
    issue_sel[RDYA] = 1'b1;
    issue_sel[RDYB] = 1'b1;
    wpos      = count - CW'(do_issue);
    count_nxt = count + CW'(do_insert) - CW'(do_issue);
    // Removing a slot collapses everything younger down by one, keeping age order.
    for (int i = 0; i < DEPTH; i++) begin
      if (do_issue && (IW'(i) >= sel)) slots_nxt[i] = woken[(i + 1) % DEPTH];
      else                             slots_nxt[i] = woken[i];
      if (do_insert && (CW'(i) == wpos)) slots_nxt[i] = ins_woken;
    end
  end

  always_ff @(posedge CLK) begin
    slots <= slots_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count       <= '0;
      issue_valid <= 1'b0;
      issue_entry <= '0;
    end else if (q.Flush_IN) begin
      count       <= '0;
      issue_valid <= 1'b0;
    end else begin
      count <= count_nxt;
      if (load) begin
        issue_valid <= found;
        if (found) issue_entry <= issue_sel;
      end
    end
  end

  assign q.Full_OUT        = full;
  assign q.Count_OUT       = count;
  assign q.Issue_entry_OUT = issue_entry;
  assign q.Issue_valid_OUT = issue_valid;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: expected issue stream in exp_q, checked at every transfer.
module tb_issue_queue;
  localparam int DEPTH = 16;
  localparam int TAG_W = 6;
  localparam int EW    = 67;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
  issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.CLK(clk), .RESET(rst_n), .q(bus));

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] a, b, e, x;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [5:0] sa, input logic ra,
                                       input logic [5:0] sb, input logic rb,
                                       input logic [5:0] dest);
    logic [5:0]  alu;
    logic [31:0] imm;
    logic [4:0]  sh;
    alu = 6'($urandom_range(0, 63));
    imm = $urandom;
    sh  = 5'($urandom_range(0, 31));
    return {alu, 1'b1, imm, sa, ra, sb, rb, sh, 1'b1, dest, 2'b00};
  endfunction

  function automatic logic [EW-1:0] rdy(input logic [EW-1:0] v);
    logic [EW-1:0] r;
    r = v;
    r[21] = 1'b1;
    r[14] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [EW-1:0] v);
    bus.Entry_IN       = v;
    bus.Entry_valid_IN = 1'b1;
  endtask

  // A transfer happens on the coming edge when valid and ready are both high out of reset/flush.
  always @(negedge clk) begin
    if (rst_n && !bus.Flush_IN && bus.Issue_valid_OUT && bus.Exec_ready_IN) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL xfer_unexpected: observed=%h expected=none", bus.Issue_entry_OUT);
      end
      if (exp_q.size() != 0) chk("xfer_entry", bus.Issue_entry_OUT, exp_q.pop_front());
    end
  end

  initial begin
    bus.Entry_IN        = '0;
    bus.Entry_valid_IN  = 1'b0;
    bus.Wakeup_valid_IN = 1'b0;
    bus.Wakeup_tag_IN   = '0;
    bus.Exec_ready_IN   = 1'b0;
    bus.Flush_IN        = 1'b0;

    // Reset
    step(); step();
    chk("rst_count", EW'(bus.Count_OUT), EW'(0));
    chk("rst_valid", EW'(bus.Issue_valid_OUT), EW'(0));
    chk("rst_entry", bus.Issue_entry_OUT, EW'(0));
    chk("rst_full", EW'(bus.Full_OUT), EW'(0));
    rst_n = 1'b1;
    step();

    // Ready ALU entry issues one edge after insert
    bus.Exec_ready_IN = 1'b1;
    e = mk(6'd0, 1'b1, 6'd0, 1'b1, 6'd5);
    exp_q.push_back(rdy(e));
    drive(e);
    step();
    bus.Entry_valid_IN = 1'b0;
    chk("t1_count_ins", EW'(bus.Count_OUT), EW'(1));
    chk("t1_valid_ins", EW'(bus.Issue_valid_OUT), EW'(0));
    step();
    chk("t1_valid", EW'(bus.Issue_valid_OUT), EW'(1));
    chk("t1_entry", bus.Issue_entry_OUT, rdy(e));
    chk("t1_count", EW'(bus.Count_OUT), EW'(0));
    step();
    chk("t1_drain", EW'(bus.Issue_valid_OUT), EW'(0));

    // Younger ready entry overtakes older waiting one; wakeup releases the older
    bus.Exec_ready_IN = 1'b0;
    a = mk(6'd7, 1'b0, 6'd0, 1'b1, 6'd11);
    b = mk(6'd0, 1'b1, 6'd0, 1'b1, 6'd12);
    drive(a); step();
    drive(b); step();
    bus.Entry_valid_IN = 1'b0;
    step();
    chk("t2_b_valid", EW'(bus.Issue_valid_OUT), EW'(1));
    chk("t2_b_entry", bus.Issue_entry_OUT, rdy(b));
    chk("t2_b_count", EW'(bus.Count_OUT), EW'(1));
    exp_q.push_back(rdy(b));
    exp_q.push_back(rdy(a));
    bus.Exec_ready_IN   = 1'b1;
    bus.Wakeup_valid_IN = 1'b1;
    bus.Wakeup_tag_IN   = 6'd7;
    step();
    bus.Wakeup_valid_IN = 1'b0;
`ifdef ISSUE_QUEUE_BYPASS_EN
    chk("t2_a_valid", EW'(bus.Issue_valid_OUT), EW'(1));
    chk("t2_a_entry", bus.Issue_entry_OUT, rdy(a));
    chk("t2_a_count", EW'(bus.Count_OUT), EW'(0));
    step();
`else
    chk("t2_a_gap", EW'(bus.Issue_valid_OUT), EW'(0));
    chk("t2_a_cnt1", EW'(bus.Count_OUT), EW'(1));
    step();
    chk("t2_a_valid", EW'(bus.Issue_valid_OUT), EW'(1));
    chk("t2_a_entry", bus.Issue_entry_OUT, rdy(a));
    chk("t2_a_count", EW'(bus.Count_OUT), EW'(0));
    step();
`endif
    chk("t2_drain", EW'(bus.Issue_valid_OUT), EW'(0));
    bus.Exec_ready_IN = 1'b0;

    // Fill: first entry parks in the output register, then 16 slots fill up
    for (int i = 0; i < 17; i++) begin
      e = mk(6'(i + 1), 1'b1, 6'd0, 1'b1, 6'(i));
      exp_q.push_back(rdy(e));
      drive(e);
      step();
    end
    chk("t3_full", EW'(bus.Full_OUT), EW'(1));
    chk("t3_count", EW'(bus.Count_OUT), EW'(DEPTH));
    drive(mk(6'd1, 1'b1, 6'd1, 1'b1, 6'd40));
    step();
    chk("t3_drop_count", EW'(bus.Count_OUT), EW'(DEPTH));
    chk("t3_drop_full", EW'(bus.Full_OUT), EW'(1));
    drive(mk(6'd2, 1'b1, 6'd2, 1'b1, 6'd41));
    bus.Exec_ready_IN = 1'b1;
    step();
    bus.Entry_valid_IN = 1'b0;
    chk("t3_one_count", EW'(bus.Count_OUT), EW'(DEPTH - 1));
    chk("t3_one_full", EW'(bus.Full_OUT), EW'(0));
    repeat (20) step();
    chk("t3_empty_count", EW'(bus.Count_OUT), EW'(0));
    chk("t3_empty_valid", EW'(bus.Issue_valid_OUT), EW'(0));
    bus.Exec_ready_IN = 1'b0;

    // Wakeup on the insert edge is captured by the inserted entry
    e = mk(6'd0, 1'b1, 6'd9, 1'b0, 6'd13);
    drive(e);
    bus.Wakeup_valid_IN = 1'b1;
    bus.Wakeup_tag_IN   = 6'd9;
    step();
    bus.Entry_valid_IN  = 1'b0;
    bus.Wakeup_valid_IN = 1'b0;
    step();
    chk("t4_valid", EW'(bus.Issue_valid_OUT), EW'(1));
    chk("t4_entry", bus.Issue_entry_OUT, rdy(e));
    chk("t4_count", EW'(bus.Count_OUT), EW'(0));
    exp_q.push_back(rdy(e));
    bus.Exec_ready_IN = 1'b1;
    step();
    chk("t4_drain", EW'(bus.Issue_valid_OUT), EW'(0));
    bus.Exec_ready_IN = 1'b0;

    // Tag 0 broadcast wakes nothing
    x = mk(6'd0, 1'b0, 6'd0, 1'b1, 6'd14);
    drive(x);
    bus.Wakeup_valid_IN = 1'b1;
    bus.Wakeup_tag_IN   = 6'd0;
    step();
    bus.Entry_valid_IN = 1'b0;
    step(); step();
    bus.Wakeup_valid_IN = 1'b0;
    chk("t5_tag0_valid", EW'(bus.Issue_valid_OUT), EW'(0));
    chk("t5_tag0_count", EW'(bus.Count_OUT), EW'(1));

    // Five queued plus a held output, then flush with a simultaneous insert
    e = mk(6'd0, 1'b1, 6'd0, 1'b1, 6'd15);
    drive(e); step();
    for (int i = 0; i < 4; i++) begin
      drive(mk(6'd20, 1'b0, 6'd0, 1'b1, 6'(16 + i)));
      step();
    end
    chk("t6_pre_count", EW'(bus.Count_OUT), EW'(5));
    chk("t6_pre_valid", EW'(bus.Issue_valid_OUT), EW'(1));
    chk("t6_pre_entry", bus.Issue_entry_OUT, rdy(e));
    drive(mk(6'd0, 1'b1, 6'd0, 1'b1, 6'd30));
    bus.Flush_IN = 1'b1;
    step();
    bus.Entry_valid_IN = 1'b0;
    bus.Flush_IN       = 1'b0;
    chk("t6_flush_count", EW'(bus.Count_OUT), EW'(0));
    chk("t6_flush_valid", EW'(bus.Issue_valid_OUT), EW'(0));
    step(); step();
    chk("t6_post_valid", EW'(bus.Issue_valid_OUT), EW'(0));
    chk("t6_post_count", EW'(bus.Count_OUT), EW'(0));

    // Reset while the output is held, with every other input active
    e = mk(6'd0, 1'b1, 6'd0, 1'b1, 6'd31);
    drive(e); step();
    bus.Entry_valid_IN = 1'b0;
    step();
    chk("t7_held", EW'(bus.Issue_valid_OUT), EW'(1));
    rst_n             = 1'b0;
    bus.Exec_ready_IN = 1'b1;
    bus.Flush_IN      = 1'b1;
    drive(mk(6'd0, 1'b1, 6'd0, 1'b1, 6'd32));
    step();
    chk("t7_rst_valid", EW'(bus.Issue_valid_OUT), EW'(0));
    chk("t7_rst_entry", bus.Issue_entry_OUT, EW'(0));
    chk("t7_rst_count", EW'(bus.Count_OUT), EW'(0));
    chk("t7_rst_full", EW'(bus.Full_OUT), EW'(0));
    rst_n              = 1'b1;
    bus.Flush_IN       = 1'b0;
    bus.Entry_valid_IN = 1'b0;
    bus.Exec_ready_IN  = 1'b0;
    step(); step();
    chk("t7_after_count", EW'(bus.Count_OUT), EW'(0));
    chk("t7_after_valid", EW'(bus.Issue_valid_OUT), EW'(0));

    chk("sb_leftover", EW'(exp_q.size()), EW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
